// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-side front end.
package regfile_wb_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned XLEN       = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of writeback sources, register-file write port and decode scoreboard signals.
interface regfile_wb_arbiter_if #(
    parameter int unsigned XLEN = regfile_wb_arbiter_pkg::XLEN
);
    import regfile_wb_arbiter_pkg::*;

    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;
    logic                  lt_issue_valid;
    logic [REG_ADDR_W-1:0] lt_issue_rd;
    logic                  lt_res_valid;
    logic                  lt_res_ready;
    logic [REG_ADDR_W-1:0] lt_res_rd;
    logic [XLEN-1:0]       lt_res_data;
    logic                  rf_write_enable;
    logic [REG_ADDR_W-1:0] rf_write_reg;
    logic [XLEN-1:0]       rf_write_data;
    logic [REG_ADDR_W-1:0] chk_rs1;
    logic [REG_ADDR_W-1:0] chk_rs2;
    logic                  stall;
    logic [NUM_REGS-1:0]   pending;

    modport master (
        output wb_valid, wb_rd, wb_data, lt_issue_valid, lt_issue_rd,
               lt_res_valid, lt_res_rd, lt_res_data, chk_rs1, chk_rs2,
        input  lt_res_ready, rf_write_enable, rf_write_reg, rf_write_data, stall, pending
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data, lt_issue_valid, lt_issue_rd,
               lt_res_valid, lt_res_rd, lt_res_data, chk_rs1, chk_rs2,
        output lt_res_ready, rf_write_enable, rf_write_reg, rf_write_data, stall, pending
    );

endinterface

// File: rtl/regfile_wb_arbiter_sync_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 37,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback over buffered long-latency results,
// plus the pending-destination scoreboard used by decode to stall.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = regfile_wb_arbiter_pkg::XLEN,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input logic                  clk,
    input logic                  reset,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int unsigned ENT_W = REG_ADDR_W + XLEN;

    logic [ENT_W-1:0]      push_data, pop_data;
    logic                  fifo_full, fifo_empty, push, pop;
    logic [CNT_W-1:0]      fifo_count;
    logic                  accept, bypass, lt_sel;
    wb_req_t               sel;
    logic                  rf_we_q;
    logic [REG_ADDR_W-1:0] rf_reg_q;
    logic [XLEN-1:0]       rf_data_q;
    logic [NUM_REGS-1:0]   pending_q, pending_d;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Ready looks only at registered occupancy, never at this cycle's pop.
    assign bus.lt_res_ready = !reset && (fifo_count < CNT_W'(DEPTH));
    assign accept           = bus.lt_res_valid && bus.lt_res_ready;
    assign push_data        = {bus.lt_res_rd, bus.lt_res_data};

    always_comb begin
        sel    = '0;
        pop    = 1'b0;
        bypass = 1'b0;
        lt_sel = 1'b0;
        if (bus.wb_valid) begin
            sel.valid = 1'b1;
            sel.rd    = bus.wb_rd;
            sel.data  = bus.wb_data;
        end else if (!fifo_empty) begin
            sel.valid = 1'b1;
            sel.rd    = pop_data[XLEN +: REG_ADDR_W];
            sel.data  = pop_data[XLEN-1:0];
            pop       = 1'b1;
            lt_sel    = 1'b1;
        end else if (accept) begin
            sel.valid = 1'b1;
            sel.rd    = bus.lt_res_rd;
            sel.data  = bus.lt_res_data;
            bypass    = 1'b1;
            lt_sel    = 1'b1;
        end
        push = accept && !bypass;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q   <= 1'b0;
            rf_reg_q  <= '0;
            rf_data_q <= '0;
        end else begin
            rf_we_q <= sel.valid && (sel.rd != '0);
            if (sel.valid && (sel.rd != '0)) begin
                rf_reg_q  <= sel.rd;
                rf_data_q <= sel.data;
            end
        end
    end

    // Set is applied after clear so a same-cycle reissue keeps the bit.
    always_comb begin
        pending_d = pending_q;
        if (lt_sel) begin
            pending_d[sel.rd] = 1'b0;
        end
        if (bus.lt_issue_valid && (bus.lt_issue_rd != '0)) begin
            pending_d[bus.lt_issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign bus.rf_write_enable = rf_we_q;
    assign bus.rf_write_reg    = rf_reg_q;
    assign bus.rf_write_data   = rf_data_q;
    assign bus.pending         = pending_q;
    assign bus.stall           = pending_q[bus.chk_rs1] | pending_q[bus.chk_rs2];

    a_one_outstanding: assert property (@(posedge clk) disable iff (reset)
        (bus.lt_issue_valid && (bus.lt_issue_rd != '0)) |->
        (!pending_q[bus.lt_issue_rd] || (lt_sel && (sel.rd == bus.lt_issue_rd))));

    a_full_not_ready: assert property (@(posedge clk) disable iff (reset)
        fifo_full |-> !bus.lt_res_ready);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios plus randomized traffic checked against a queue-based reference model.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned XL    = 32;

    typedef struct {
        logic [4:0]    rd;
        logic [XL-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   ncmp = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.XLEN(XL)) bus ();

    regfile_wb_arbiter #(.DEPTH(DEPTH), .XLEN(XL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model state
    ent_t          mq[$];
    logic [31:0]   m_pend;
    logic          m_we;
    logic [4:0]    m_reg;
    logic [XL-1:0] m_data;

    task automatic idle();
        bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0;
        bus.lt_issue_valid = 0; bus.lt_issue_rd = 0;
        bus.lt_res_valid = 0; bus.lt_res_rd = 0; bus.lt_res_data = 0;
        bus.chk_rs1 = 0; bus.chk_rs2 = 0;
    endtask

    // Advance one clock and evolve the reference model from the inputs seen at the edge.
    task automatic step();
        ent_t          q_next[$];
        logic [31:0]   p = m_pend;
        logic          we = 0;
        logic [4:0]    rg = m_reg;
        logic [XL-1:0] dt = m_data;
        logic          v = 0, from_lt = 0, acc;
        logic [4:0]    srd = 0;
        logic [XL-1:0] sdt = 0;
        ent_t          e;
        q_next = mq;
        if (reset) begin
            q_next.delete(); p = 0; rg = 0; dt = 0;
        end else begin
            acc = bus.lt_res_valid && (mq.size() < DEPTH);
            if (bus.wb_valid) begin
                v = 1; srd = bus.wb_rd; sdt = bus.wb_data;
            end else if (q_next.size() > 0) begin
                e = q_next.pop_front(); v = 1; from_lt = 1; srd = e.rd; sdt = e.data;
            end else if (acc) begin
                v = 1; from_lt = 1; srd = bus.lt_res_rd; sdt = bus.lt_res_data; acc = 0;
            end
            if (acc) begin
                e.rd = bus.lt_res_rd; e.data = bus.lt_res_data; q_next.push_back(e);
            end
            if (v && srd != 0) begin
                we = 1; rg = srd; dt = sdt;
            end
            if (from_lt) p[srd] = 0;
            if (bus.lt_issue_valid && bus.lt_issue_rd != 0) p[bus.lt_issue_rd] = 1;
            p[0] = 0;
        end
        @(posedge clk);
        #1;
        mq = q_next; m_pend = p; m_we = we; m_reg = rg; m_data = dt;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        step(); step();
        ncmp++; if (bus.rf_write_enable !== 1'b0) begin nfail++; $display("FAIL reset_we: got %0b want 0", bus.rf_write_enable); end
        ncmp++; if (bus.lt_res_ready !== 1'b0) begin nfail++; $display("FAIL reset_ready: got %0b want 0", bus.lt_res_ready); end
        ncmp++; if (bus.rf_write_reg !== 5'd0 || bus.rf_write_data !== 32'd0) begin nfail++; $display("FAIL reset_regdata: got %0d/%0h want 0/0", bus.rf_write_reg, bus.rf_write_data); end
        reset = 0;
        step();
        ncmp++; if (bus.rf_write_enable !== 1'b0) begin nfail++; $display("FAIL idle_we: got %0b want 0", bus.rf_write_enable); end
        ncmp++; if (bus.pending !== 32'd0) begin nfail++; $display("FAIL idle_pending: got %0h want 0", bus.pending); end
        ncmp++; if (bus.lt_res_ready !== 1'b1) begin nfail++; $display("FAIL idle_ready: got %0b want 1", bus.lt_res_ready); end
    endtask

    task automatic test_wb_write();
        bus.wb_valid = 1; bus.wb_rd = 5; bus.wb_data = 32'hDEAD_BEEF;
        step();
        idle();
        ncmp++; if ({bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_data} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin nfail++; $display("FAIL wb_write: got %0b/%0d/%0h want 1/5/deadbeef", bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_data); end
        step();
        ncmp++; if ({bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_data} !== {1'b0, 5'd5, 32'hDEAD_BEEF}) begin nfail++; $display("FAIL wb_hold: got %0b/%0d/%0h want 0/5/deadbeef", bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_data); end
    endtask

    task automatic test_bypass();
        bus.lt_issue_valid = 1; bus.lt_issue_rd = 7;
        step();
        idle();
        bus.chk_rs1 = 7;
        #1;
        ncmp++; if (bus.stall !== 1'b1 || bus.pending[7] !== 1'b1) begin nfail++; $display("FAIL issue_stall: got %0b/%0b want 1/1", bus.stall, bus.pending[7]); end
        bus.lt_res_valid = 1; bus.lt_res_rd = 7; bus.lt_res_data = 32'h1234;
        step();
        idle();
        bus.chk_rs1 = 7;
        #1;
        ncmp++; if ({bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_data} !== {1'b1, 5'd7, 32'h1234}) begin nfail++; $display("FAIL bypass_write: got %0b/%0d/%0h want 1/7/1234", bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_data); end
        ncmp++; if (bus.pending[7] !== 1'b0 || bus.stall !== 1'b0) begin nfail++; $display("FAIL bypass_clear: got %0b/%0b want 0/0", bus.pending[7], bus.stall); end
    endtask

    task automatic test_fifo_fill();
        logic [4:0]  rds[4]  = '{5'd8, 5'd9, 5'd10, 5'd0};
        logic [31:0] dats[4] = '{32'h88, 32'h99, 32'hAA, 32'h0};
        logic        rdy[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            bus.wb_valid = 1; bus.wb_rd = 3; bus.wb_data = 32'h300 + i;
            bus.lt_res_valid = (i < 3); bus.lt_res_rd = rds[i]; bus.lt_res_data = dats[i];
            #1;
            ncmp++; if (bus.lt_res_ready !== rdy[i]) begin nfail++; $display("FAIL fill_ready%0d: got %0b want %0b", i, bus.lt_res_ready, rdy[i]); end
            step();
            ncmp++; if (bus.rf_write_enable !== 1'b1 || bus.rf_write_reg !== 5'd3) begin nfail++; $display("FAIL fill_wb%0d: got %0b/%0d want 1/3", i, bus.rf_write_enable, bus.rf_write_reg); end
        end
        idle();
        step();
        ncmp++; if ({bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_data} !== {1'b1, 5'd8, 32'h88}) begin nfail++; $display("FAIL drain_first: got %0b/%0d/%0h want 1/8/88", bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_data); end
        step();
        ncmp++; if ({bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_data} !== {1'b1, 5'd9, 32'h99}) begin nfail++; $display("FAIL drain_second: got %0b/%0d/%0h want 1/9/99", bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_data); end
        step();
        ncmp++; if (bus.rf_write_enable !== 1'b0 || bus.lt_res_ready !== 1'b1) begin nfail++; $display("FAIL drain_done: got %0b/%0b want 0/1", bus.rf_write_enable, bus.lt_res_ready); end
    endtask

    task automatic test_x0();
        bus.wb_valid = 1; bus.wb_rd = 0; bus.wb_data = 32'h1;
        step();
        idle();
        ncmp++; if (bus.rf_write_enable !== 1'b0) begin nfail++; $display("FAIL x0_wb: got %0b want 0", bus.rf_write_enable); end
        bus.lt_res_valid = 1; bus.lt_res_rd = 0; bus.lt_res_data = 32'h2;
        step();
        idle();
        ncmp++; if (bus.rf_write_enable !== 1'b0) begin nfail++; $display("FAIL x0_bypass: got %0b want 0", bus.rf_write_enable); end
        for (int i = 0; i < 2; i++) begin
            bus.wb_valid = 1; bus.wb_rd = 4; bus.wb_data = 32'h4;
            bus.lt_res_valid = 1; bus.lt_res_rd = 0; bus.lt_res_data = 32'h50 + i;
            step();
        end
        idle();
        for (int i = 0; i < 2; i++) begin
            step();
            ncmp++; if (bus.rf_write_enable !== 1'b0) begin nfail++; $display("FAIL x0_pop%0d: got %0b want 0", i, bus.rf_write_enable); end
        end
        // A fresh result bypasses only if the FIFO really drained.
        bus.lt_res_valid = 1; bus.lt_res_rd = 11; bus.lt_res_data = 32'hB0B;
        step();
        idle();
        ncmp++; if ({bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_data} !== {1'b1, 5'd11, 32'hB0B}) begin nfail++; $display("FAIL x0_drained: got %0b/%0d/%0h want 1/11/b0b", bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_data); end
    endtask

    task automatic test_reset_mid();
        bus.lt_issue_valid = 1; bus.lt_issue_rd = 8;
        step();
        idle();
        for (int i = 0; i < 2; i++) begin
            bus.wb_valid = 1; bus.wb_rd = 3; bus.wb_data = 32'h3;
            bus.lt_res_valid = 1; bus.lt_res_rd = 8 + i; bus.lt_res_data = 32'h808 + i;
            step();
        end
        idle();
        #1;
        ncmp++; if (bus.pending[8] !== 1'b1 || bus.lt_res_ready !== 1'b0) begin nfail++; $display("FAIL pre_reset: got %0b/%0b want 1/0", bus.pending[8], bus.lt_res_ready); end
        reset = 1;
        step();
        reset = 0;
        step();
        ncmp++; if (bus.rf_write_enable !== 1'b0 || bus.pending !== 32'd0 || bus.lt_res_ready !== 1'b1) begin nfail++; $display("FAIL post_reset: got %0b/%0h/%0b want 0/0/1", bus.rf_write_enable, bus.pending, bus.lt_res_ready); end
        bus.lt_res_valid = 1; bus.lt_res_rd = 12; bus.lt_res_data = 32'hC0C;
        step();
        idle();
        ncmp++; if ({bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_data} !== {1'b1, 5'd12, 32'hC0C}) begin nfail++; $display("FAIL post_reset_empty: got %0b/%0d/%0h want 1/12/c0c", bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_data); end
    endtask

    task automatic test_issue_pop_same();
        bus.lt_issue_valid = 1; bus.lt_issue_rd = 10;
        step();
        idle();
        bus.wb_valid = 1; bus.wb_rd = 3; bus.wb_data = 32'h3;
        bus.lt_res_valid = 1; bus.lt_res_rd = 10; bus.lt_res_data = 32'h1010;
        step();
        idle();
        bus.lt_issue_valid = 1; bus.lt_issue_rd = 10;
        step();
        idle();
        ncmp++; if ({bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_data} !== {1'b1, 5'd10, 32'h1010}) begin nfail++; $display("FAIL same_pop_write: got %0b/%0d/%0h want 1/10/1010", bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_data); end
        ncmp++; if (bus.pending[10] !== 1'b1) begin nfail++; $display("FAIL same_set_wins: got %0b want 1", bus.pending[10]); end
        bus.lt_res_valid = 1; bus.lt_res_rd = 10; bus.lt_res_data = 32'h2020;
        step();
        idle();
        ncmp++; if (bus.pending[10] !== 1'b0 || bus.rf_write_data !== 32'h2020) begin nfail++; $display("FAIL same_final_clear: got %0b/%0h want 0/2020", bus.pending[10], bus.rf_write_data); end
    endtask

    task automatic test_random();
        logic [4:0] outs[$];
        int         idx;
        logic [4:0] r;
        logic       exp_stall, exp_ready;
        for (int cyc = 0; cyc < 600; cyc++) begin
            idle();
            bus.wb_valid = ($urandom_range(0, 2) == 0);
            bus.wb_rd    = 5'($urandom_range(0, 31));
            bus.wb_data  = $urandom;
            r = 5'($urandom_range(1, 31));
            if ($urandom_range(0, 2) == 0 && !m_pend[r]) begin
                bus.lt_issue_valid = 1; bus.lt_issue_rd = r;
            end
            idx = -1;
            if (outs.size() > 0 && $urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, outs.size() - 1);
                bus.lt_res_valid = 1; bus.lt_res_rd = outs[idx]; bus.lt_res_data = $urandom;
            end
            bus.chk_rs1 = 5'($urandom_range(0, 31));
            bus.chk_rs2 = 5'($urandom_range(0, 31));
            #1;
            exp_stall = m_pend[bus.chk_rs1] | m_pend[bus.chk_rs2];
            exp_ready = (mq.size() < DEPTH);
            ncmp++; if (bus.stall !== exp_stall) begin nfail++; $display("FAIL rnd_stall c%0d: got %0b want %0b", cyc, bus.stall, exp_stall); end
            ncmp++; if (bus.lt_res_ready !== exp_ready) begin nfail++; $display("FAIL rnd_ready c%0d: got %0b want %0b", cyc, bus.lt_res_ready, exp_ready); end
            if (idx >= 0 && exp_ready) outs.delete(idx);
            if (bus.lt_issue_valid) outs.push_back(bus.lt_issue_rd);
            step();
            ncmp++; if ({bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_data} !== {m_we, m_reg, m_data}) begin nfail++; $display("FAIL rnd_write c%0d: got %0b/%0d/%0h want %0b/%0d/%0h", cyc, bus.rf_write_enable, bus.rf_write_reg, bus.rf_write_data, m_we, m_reg, m_data); end
            ncmp++; if (bus.pending !== m_pend) begin nfail++; $display("FAIL rnd_pending c%0d: got %0h want %0h", cyc, bus.pending, m_pend); end
        end
    endtask

    initial begin
        m_pend = 0; m_we = 0; m_reg = 0; m_data = 0;
        idle();
        test_reset();
        test_wb_write();
        test_bypass();
        test_fifo_fill();
        test_x0();
        test_reset_mid();
        test_issue_pop_same();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
